mem_arbiter: RTL

- Shares the single-port instruction/data memory between two requesters: the multi-cycle stack CPU (port C) and the program loader/debug port (port L).
- Each requester raises a level request with a stable address, write flag and write data. The arbiter sequences one memory access at a time and returns a one-cycle done pulse.
- The CPU controller waits in its memory states until c_done, so memory latency is hidden behind this block.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing the single-port instruction/data memory
// between the stack CPU (port C) and the program loader/debug port (port L).
//
//   state  | meaning
//   IDLE   | sample requests, grant one port, latch its address/we/wdata
//   ACCESS | drive the memory; count down read latency, capture read data
//   RESP   | one-cycle done pulse to the grantee, memory strobes low
module mem_arbiter #(
   parameter int AW      = 5,
   parameter int DW      = 8,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_done,
   output logic [DW-1:0] c_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_done,
   output logic [DW-1:0] l_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_rd,
   output logic          mem_wr,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [2:0] CNT_RD = 3'(MEM_LAT - 1);

   state_t        state_q;
   logic [2:0]    cnt_q;
   logic          owner_q;
   logic          last_owner_q;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] c_rdata_q;
   logic [DW-1:0] l_rdata_q;
   logic          c_done_q;
   logic          l_done_q;
   logic          mem_rd_q;
   logic          mem_wr_q;
   logic          busy_q;

   logic          gnt_valid_d;
   logic          gnt_l_d;
   logic          gnt_we_d;
   logic [AW-1:0] gnt_addr_d;
   logic [DW-1:0] gnt_wdata_d;

   // On a tie the port that did not win last time gets the memory.
   always_comb begin
      gnt_valid_d = c_req | l_req;
      gnt_l_d     = l_req & (~c_req | ~last_owner_q);
      gnt_we_d    = gnt_l_d ? l_we    : c_we;
      gnt_addr_d  = gnt_l_d ? l_addr  : c_addr;
      gnt_wdata_d = gnt_l_d ? l_wdata : c_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         c_rdata_q    <= '0;
         l_rdata_q    <= '0;
         c_done_q     <= 1'b0;
         l_done_q     <= 1'b0;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_valid_d) begin
                  owner_q      <= gnt_l_d;
                  last_owner_q <= gnt_l_d;
                  addr_q       <= gnt_addr_d;
                  we_q         <= gnt_we_d;
                  wdata_q      <= gnt_wdata_d;
                  cnt_q        <= gnt_we_d ? 3'd0 : CNT_RD;
                  mem_rd_q     <= ~gnt_we_d;
                  mem_wr_q     <= gnt_we_d;
                  busy_q       <= 1'b1;
                  state_q      <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q != 3'd0) begin
                  cnt_q <= cnt_q - 3'd1;
               end else begin
                  if (!we_q) begin
                     if (owner_q) l_rdata_q <= mem_rdata;
                     else         c_rdata_q <= mem_rdata;
                  end
                  mem_rd_q <= 1'b0;
                  mem_wr_q <= 1'b0;
                  c_done_q <= ~owner_q;
                  l_done_q <= owner_q;
                  state_q  <= RESP;
               end
            end
            RESP: begin
               c_done_q <= 1'b0;
               l_done_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               c_done_q <= 1'b0;
               l_done_q <= 1'b0;
               mem_rd_q <= 1'b0;
               mem_wr_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   // The latched address/data only change at a grant, so they double as the
   // memory bus and naturally hold their last value outside ACCESS.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign c_done    = c_done_q;
   assign l_done    = l_done_q;
   assign c_rdata   = c_rdata_q;
   assign l_rdata   = l_rdata_q;
   assign busy      = busy_q;
   assign owner     = owner_q;

endmodule
